// File: rtl/combination_sweep_controller_pkg.sv
// Shared definitions for the combination sweep sequencer: default geometry of
// the joltage-halving solver, derived width helpers and the sweep FSM state.
package combination_sweep_controller_pkg;

    localparam int unsigned DEF_MAX_BUTTON_COUNT = 13;
    localparam int unsigned DEF_MACHINE_COUNT    = 10;
    localparam int unsigned DEF_BITS_PER_JOLTAGE = 9;

    // Widths for the default geometry; modules derive their own from parameters.
    localparam int unsigned PRESS_W = $clog2(DEF_MAX_BUTTON_COUNT + 1);
    localparam int unsigned COUNT_W = DEF_MAX_BUTTON_COUNT + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_t;

    // Bits needed to hold a press count of 0..n.
    function automatic int unsigned press_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/combination_sweep_controller_result_fifo2.sv
// result_fifo2: two-entry FIFO holding {new_target, presses} results.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (clears storage too)
//   push/push_data write one entry (ignored when full unless popping)
//   pop            remove the head entry (ignored when empty)
//   head_data      current head entry
//   occupancy      number of stored entries, 0..2
module result_fifo2
    import combination_sweep_controller_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_MACHINE_COUNT * DEF_BITS_PER_JOLTAGE + PRESS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop    = pop & (occupancy != 2'd0);
        do_push   = push & ((occupancy != 2'd2) | do_pop);
        head_data = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/combination_sweep_controller.sv
// combination_sweep_controller: per-level sequencer for the combination
// datapath. Enumerates every button combination whose per-machine press
// parity matches the target LSBs, issues each to the datapath, drops results
// flagged negative and streams surviving halved targets with their press
// counts downstream in ascending combination order.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       one-cycle request, honoured only in IDLE
//   button_count                active buttons for this sweep
//   flattened_buttons/_target   problem inputs, latched on start
//   busy, done                  sweep in progress / completion pulse
//   result_count                results delivered in current/last sweep
//   dp_combination              combination presented to the datapath
//   dp_flattened_buttons/_target latched inputs presented to the datapath
//   dp_combination_no_negative  registered datapath flag (1 cycle after issue)
//   dp_flattened_new_target     registered datapath result
//   out_valid/out_ready         result handshake
//   out_new_target, out_presses result payload
module combination_sweep_controller
    import combination_sweep_controller_pkg::*;
#(
    parameter int unsigned MAX_BUTTON_COUNT = DEF_MAX_BUTTON_COUNT,
    parameter int unsigned MACHINE_COUNT    = DEF_MACHINE_COUNT,
    parameter int unsigned BITS_PER_JOLTAGE = DEF_BITS_PER_JOLTAGE
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]     button_count,
    input  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0] flattened_buttons,
    input  logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0] flattened_target,
    output logic                                      busy,
    output logic                                      done,
    output logic [MAX_BUTTON_COUNT:0]                 result_count,
    output logic [MAX_BUTTON_COUNT-1:0]               dp_combination,
    output logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0] dp_flattened_buttons,
    output logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0] dp_flattened_target,
    input  logic                                      dp_combination_no_negative,
    input  logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0] dp_flattened_new_target,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0] out_new_target,
    output logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]     out_presses
);

    localparam int unsigned PRESS_BITS = press_width(MAX_BUTTON_COUNT);
    localparam int unsigned COUNT_BITS = MAX_BUTTON_COUNT + 1;
    localparam int unsigned TARGET_W   = MACHINE_COUNT * BITS_PER_JOLTAGE;
    localparam int unsigned ENTRY_W    = TARGET_W + PRESS_BITS;

    sweep_state_t            state;
    logic [COUNT_BITS-1:0]   cand;
    logic [COUNT_BITS-1:0]   last_cand;
    logic [PRESS_BITS-1:0]   bc_q;
    logic                    in_flight;
    logic [PRESS_BITS-1:0]   flight_presses;

    logic [MACHINE_COUNT-1:0] parity;
    logic [MACHINE_COUNT-1:0] target_lsb;
    logic [PRESS_BITS-1:0]    cand_presses;
    logic                     parity_ok;
    logic [2:0]               outstanding;
    logic                     credit_ok;
    logic                     sweeping;
    logic                     issue;
    logic                     advance;
    logic                     push;
    logic                     pop;
    logic [1:0]               occupancy;
    logic [ENTRY_W-1:0]       head;

    // Parity of presses landing on each machine for the current candidate.
    always_comb begin
        parity = '0;
        for (int unsigned j = 0; j < MAX_BUTTON_COUNT; j++) begin
            for (int unsigned i = 0; i < MACHINE_COUNT; i++) begin
                parity[i] = parity[i] ^ (dp_flattened_buttons[j*MACHINE_COUNT+i] & cand[j]);
            end
        end
    end

    always_comb begin
        target_lsb = '0;
        for (int unsigned i = 0; i < MACHINE_COUNT; i++) begin
            target_lsb[i] = dp_flattened_target[i*BITS_PER_JOLTAGE];
        end
    end

    always_comb begin
        cand_presses = '0;
        for (int unsigned j = 0; j < MAX_BUTTON_COUNT; j++) begin
            cand_presses = cand_presses + PRESS_BITS'(cand[j]);
        end
    end

    always_comb begin
        last_cand   = (COUNT_BITS'(1) << bc_q) - COUNT_BITS'(1);
        sweeping    = (state == ST_SWEEP);
        parity_ok   = (parity == target_lsb);
        pop         = out_valid & out_ready;
        // Entries already stored plus the one returning next cycle; a pop this
        // cycle frees a slot, so the new issue still always finds room.
        outstanding = 3'(occupancy) + 3'(in_flight);
        credit_ok   = outstanding < (3'd2 + 3'(pop));
        issue       = sweeping & parity_ok & credit_ok;
        // Failing candidates are skipped without waiting for credit.
        advance     = sweeping & (~parity_ok | credit_ok);
        push        = in_flight & dp_combination_no_negative;
    end

    assign dp_combination = cand[MAX_BUTTON_COUNT-1:0];

    result_fifo2 #(
        .WIDTH (ENTRY_W)
    ) u_result_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({dp_flattened_new_target, flight_presses}),
        .pop       (pop),
        .head_data (head),
        .occupancy (occupancy)
    );

    assign out_valid      = (occupancy != 2'd0);
    assign out_new_target = head[PRESS_BITS +: TARGET_W];
    assign out_presses    = head[PRESS_BITS-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_IDLE;
            cand                 <= '0;
            bc_q                 <= '0;
            in_flight            <= 1'b0;
            flight_presses       <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            result_count         <= '0;
            dp_flattened_buttons <= '0;
            dp_flattened_target  <= '0;
        end else begin
            done      <= 1'b0;
            in_flight <= issue;
            if (issue) begin
                flight_presses <= cand_presses;
            end
            if (pop) begin
                result_count <= result_count + COUNT_BITS'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dp_flattened_buttons <= flattened_buttons;
                        dp_flattened_target  <= flattened_target;
                        bc_q         <= (button_count > PRESS_BITS'(MAX_BUTTON_COUNT))
                                        ? PRESS_BITS'(MAX_BUTTON_COUNT) : button_count;
                        cand         <= '0;
                        result_count <= '0;
                        busy         <= 1'b1;
                        state        <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (advance) begin
                        // cand holds at the last value so upper bits stay clear.
                        if (cand == last_cand) begin
                            state <= ST_DRAIN;
                        end else begin
                            cand <= cand + COUNT_BITS'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!in_flight && (occupancy == 2'd0)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_combination_sweep_controller.sv
module tb_combination_sweep_controller;

    localparam int MB = 13;
    localparam int MC = 10;
    localparam int BJ = 9;
    localparam int TW = MC * BJ;
    localparam int BW = MC * MB;
    localparam int PW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] button_count = '0;
    logic [BW-1:0] flattened_buttons = '0;
    logic [TW-1:0] flattened_target = '0;
    logic          busy;
    logic          done;
    logic [MB:0]   result_count;
    logic [MB-1:0] dp_combination;
    logic [BW-1:0] dp_flattened_buttons;
    logic [TW-1:0] dp_flattened_target;
    logic          dp_flag = 1'b0;
    logic [TW-1:0] dp_new = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TW-1:0] out_new_target;
    logic [PW-1:0] out_presses;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [TW-1:0] t;
        int            p;
    } res_t;
    res_t exp_q[$];

    typedef struct {
        int            bc;
        logic [BW-1:0] btn;
        logic [TW-1:0] tgt;
        int            mode;       // 0 ready high, 1 random ready, 2 backpressure pattern
        int            exp_count;
        int            exp_first;  // cycle of first out_valid, 0 = not checked
        int            exp_done;   // cycle of done pulse, 0 = not checked
    } vec_t;
    vec_t vecs[6];

    combination_sweep_controller #(
        .MAX_BUTTON_COUNT (MB),
        .MACHINE_COUNT    (MC),
        .BITS_PER_JOLTAGE (BJ)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .start                      (start),
        .button_count               (button_count),
        .flattened_buttons          (flattened_buttons),
        .flattened_target           (flattened_target),
        .busy                       (busy),
        .done                       (done),
        .result_count               (result_count),
        .dp_combination             (dp_combination),
        .dp_flattened_buttons       (dp_flattened_buttons),
        .dp_flattened_target        (dp_flattened_target),
        .dp_combination_no_negative (dp_flag),
        .dp_flattened_new_target    (dp_new),
        .out_valid                  (out_valid),
        .out_ready                  (out_ready),
        .out_new_target             (out_new_target),
        .out_presses                (out_presses)
    );

    always #5 clk = ~clk;

    // Presses of combination comb that land on machine i.
    function automatic int hits(input logic [MB-1:0] comb, input logic [BW-1:0] btn, input int i);
        int h = 0;
        for (int j = 0; j < MB; j++) if (comb[j] && btn[j*MC+i]) h++;
        return h;
    endfunction

    function automatic bit non_negative(input logic [MB-1:0] comb, input logic [BW-1:0] btn,
                                        input logic [TW-1:0] tgt);
        for (int i = 0; i < MC; i++) begin
            if (int'(tgt[i*BJ +: BJ]) < hits(comb, btn, i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [TW-1:0] halved(input logic [MB-1:0] comb, input logic [BW-1:0] btn,
                                             input logic [TW-1:0] tgt);
        logic [TW-1:0] r = '0;
        int d;
        for (int i = 0; i < MC; i++) begin
            d = int'(tgt[i*BJ +: BJ]) - hits(comb, btn, i);
            if (d >= 0) r[i*BJ +: BJ] = BJ'(d / 2);
        end
        return r;
    endfunction

    // Combination datapath stand-in: registered result one cycle after issue.
    always @(posedge clk) begin
        dp_flag <= non_negative(dp_combination, dp_flattened_buttons, dp_flattened_target);
        dp_new  <= halved(dp_combination, dp_flattened_buttons, dp_flattened_target);
    end

    // Reference: every combination of the active buttons whose residual
    // (target - presses) is even on every machine and non-negative everywhere.
    task automatic build_expected(input int bc, input logic [BW-1:0] btn, input logic [TW-1:0] tgt);
        logic [MB-1:0] cv;
        bit even;
        res_t e;
        exp_q.delete();
        for (int c = 0; c < (1 << bc); c++) begin
            cv = MB'(c);
            even = 1'b1;
            for (int i = 0; i < MC; i++) begin
                if (((int'(tgt[i*BJ +: BJ]) - hits(cv, btn, i)) & 1) != 0) even = 1'b0;
            end
            if (even && non_negative(cv, btn, tgt)) begin
                e.t = halved(cv, btn, tgt);
                e.p = $countones(cv);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_valid"}, 128'(out_valid), 128'(0));
        check({tag, "_count"}, 128'(result_count), 128'(0));
        check({tag, "_comb"}, 128'(dp_combination), 128'(0));
        check({tag, "_out_target"}, 128'(out_new_target), 128'(0));
        check({tag, "_out_presses"}, 128'(out_presses), 128'(0));
        check({tag, "_dp_target"}, 128'(dp_flattened_target), 128'(0));
        check({tag, "_dp_buttons"}, 128'(|dp_flattened_buttons), 128'(0));
    endtask

    task automatic run_sweep(input int bc, input logic [BW-1:0] btn, input logic [TW-1:0] tgt,
                             input int mode, input bit poke, output int done_cyc, output int first_cyc);
        int cyc;
        int exp_n;
        bit stalled;
        bit finished;
        logic [TW-1:0] held_t;
        logic [PW-1:0] held_p;
        res_t e;
        build_expected(bc, btn, tgt);
        exp_n = exp_q.size();
        done_cyc = 0;
        first_cyc = 0;
        stalled = 1'b0;
        finished = 1'b0;
        held_t = '0;
        held_p = '0;
        @(negedge clk);
        button_count = PW'(bc);
        flattened_buttons = btn;
        flattened_target = tgt;
        start = 1'b1;
        out_ready = (mode == 0);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!finished && cyc < 20000) begin
            if (cyc == 1) check("busy_after_start", 128'(busy), 128'(1));
            if (poke && cyc == 2) begin
                start = 1'b1;
                flattened_target = ~tgt;
            end
            if (poke && cyc == 3) begin
                start = 1'b0;
                flattened_target = tgt;
            end
            if (poke && cyc == 4) check("target_kept", 128'(dp_flattened_target), 128'(tgt));
            if (stalled) begin
                check("hold_valid", 128'(out_valid), 128'(1));
                check("hold_target", 128'(out_new_target), 128'(held_t));
                check("hold_presses", 128'(out_presses), 128'(held_p));
            end
            if (mode == 2 && cyc == 11) begin
                check("stall_comb", 128'(dp_combination), 128'(2));
                check("stall_valid", 128'(out_valid), 128'(1));
                check("stall_count", 128'(result_count), 128'(0));
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1'b1;
            end else begin
                case (mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = 1'($urandom_range(0, 1));
                    default: out_ready = (cyc > 11) && (cyc % 2 == 1);
                endcase
                if (out_valid && first_cyc == 0) first_cyc = cyc;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_result: got presses %0d target %0h, expected none",
                                 out_presses, out_new_target);
                    end else begin
                        e = exp_q.pop_front();
                        check("result_target", 128'(out_new_target), 128'(e.t));
                        check("result_presses", 128'(out_presses), 128'(e.p));
                    end
                end
                stalled = out_valid && !out_ready;
                held_t = out_new_target;
                held_p = out_presses;
                @(negedge clk);
                cyc++;
            end
        end
        out_ready = 1'b0;
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
        end else begin
            check("result_count_model", 128'(result_count), 128'(exp_n));
            check("all_results_seen", 128'(exp_q.size()), 128'(0));
            @(negedge clk);
            check("done_one_cycle", 128'(done), 128'(0));
            check("idle_not_busy", 128'(busy), 128'(0));
        end
    endtask

    initial begin
        logic [BW-1:0] btn3;
        logic [TW-1:0] tgt;
        logic [BW-1:0] rb;
        logic [TW-1:0] rt;
        int dc;
        int fc;
        int rbc;

        btn3 = '0;
        btn3[0*MC+0] = 1'b1;
        btn3[0*MC+1] = 1'b1;
        btn3[1*MC+1] = 1'b1;
        btn3[2*MC+1] = 1'b1;

        // Full match: 011 and 101 leave an even, non-negative residual.
        tgt = '0; tgt[0 +: BJ] = 9'd1; tgt[BJ +: BJ] = 9'd2;
        vecs[0] = '{3, btn3, tgt, 0, 2, 0, 0};
        // Negative drop: 001 and 111 pass parity, 111 overdraws machine 1.
        tgt = '0; tgt[0 +: BJ] = 9'd1; tgt[BJ +: BJ] = 9'd1;
        vecs[1] = '{3, btn3, tgt, 0, 1, 4, 0};
        // Backpressure: every combination passes.
        vecs[2] = '{4, '0, '0, 2, 16, 0, 0};
        // Odd target, no buttons: nothing emitted, done in cycle 3.
        tgt = '0; tgt[0 +: BJ] = 9'd1;
        vecs[3] = '{0, btn3, tgt, 0, 0, 0, 3};
        // Zero target, no buttons: combination 0 only.
        vecs[4] = '{0, btn3, '0, 0, 1, 3, 5};
        // Full button width, one candidate per cycle.
        vecs[5] = '{13, '0, '0, 0, 8192, 3, 8196};

        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        for (int v = 0; v < 6; v++) begin
            run_sweep(vecs[v].bc, vecs[v].btn, vecs[v].tgt, vecs[v].mode, 1'b0, dc, fc);
            check($sformatf("vec%0d_result_count", v), 128'(result_count), 128'(vecs[v].exp_count));
            if (vecs[v].exp_first != 0)
                check($sformatf("vec%0d_first_valid_cycle", v), 128'(fc), 128'(vecs[v].exp_first));
            if (vecs[v].exp_done != 0)
                check($sformatf("vec%0d_done_cycle", v), 128'(dc), 128'(vecs[v].exp_done));
        end

        // Start pulse during SWEEP with a different target must be ignored.
        run_sweep(vecs[1].bc, vecs[1].btn, vecs[1].tgt, 0, 1'b1, dc, fc);
        check("busy_start_result_count", 128'(result_count), 128'(1));

        // Reset in the middle of a backpressured sweep with the FIFO full.
        @(negedge clk);
        button_count = PW'(4);
        flattened_buttons = '0;
        flattened_target = '0;
        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_reset_valid", 128'(out_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        check("no_done_in_reset", 128'(done), 128'(0));
        rst_n = 1'b1;
        run_sweep(vecs[0].bc, vecs[0].btn, vecs[0].tgt, 0, 1'b0, dc, fc);
        check("post_reset_result_count", 128'(result_count), 128'(vecs[0].exp_count));

        // Random sweeps against the reference model with random backpressure.
        for (int n = 0; n < 25; n++) begin
            rbc = $urandom_range(0, 6);
            rb = '0;
            for (int k = 0; k < BW; k++) rb[k] = ($urandom_range(0, 3) == 0);
            rt = '0;
            for (int i = 0; i < MC; i++) rt[i*BJ +: BJ] = BJ'($urandom_range(0, 6));
            run_sweep(rbc, rb, rt, 1, 1'b0, dc, fc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
